// File: rtl/btb_update_queue.sv
// Coalescing FIFO between the commit stage and the single BTB write port.
// Taken branches are queued (one pending update per PC) and drained one per cycle.
module btb_update_queue #(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             resolve_valid,
  output logic             resolve_ready,
  input  logic [31:0]      resolve_pc,
  input  logic [31:0]      resolve_target,
  input  logic             resolve_taken,
  output logic             btb_w_en,
  output logic [31:0]      btb_commit_pc,
  output logic [31:0]      btb_actual_target_addr,
  input  logic             btb_wr_ready,
  output logic [CNT_W-1:0] occupancy
);

  localparam int PTR_W = $clog2(DEPTH);

  // Handshakes: a resolve transfer happens on resolve_valid & resolve_ready;
  // a BTB write retires on btb_w_en & btb_wr_ready. Both sides use only
  // registered state to form their valid/ready, so there are no comb loops.

  logic [DEPTH-1:0] r_valid;
  logic [31:0]      r_pc  [DEPTH];
  logic [31:0]      r_tgt [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic             w_deq;
  logic             w_acc;
  logic             w_hit;
  logic [PTR_W-1:0] w_hit_idx;
  logic             w_alloc;

  assign resolve_ready = (r_count != CNT_W'(DEPTH));
  assign btb_w_en      = (r_count != '0);
  assign occupancy     = r_count;

  assign btb_commit_pc          = btb_w_en ? r_pc[r_head]  : 32'h0;
  assign btb_actual_target_addr = btb_w_en ? r_tgt[r_head] : 32'h0;

  assign w_deq = btb_w_en & btb_wr_ready;
  assign w_acc = resolve_valid & resolve_ready & resolve_taken;

  // A head entry that leaves this cycle must not absorb the new target,
  // otherwise the update would be lost with the retiring write.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && (r_pc[i] == resolve_pc) &&
          !(w_deq && (PTR_W'(i) == r_head))) begin
        w_hit     = 1'b1;
        w_hit_idx = PTR_W'(i);
      end
    end
  end

  assign w_alloc = w_acc & ~w_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_pc[i]  <= 32'h0;
        r_tgt[i] <= 32'h0;
      end
    end else begin
      if (w_deq) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PTR_W'(1);
      end
      if (w_acc && w_hit) begin
        r_tgt[w_hit_idx] <= resolve_target;
      end
      if (w_alloc) begin
        r_valid[r_tail] <= 1'b1;
        r_pc[r_tail]    <= resolve_pc;
        r_tgt[r_tail]   <= resolve_target;
        r_tail          <= r_tail + PTR_W'(1);
      end
      case ({w_alloc, w_deq})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  a_count_bound : assert property (@(posedge clk) disable iff (!rst_n)
    r_count <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_btb_update_queue.sv
// Directed bench for btb_update_queue: per-cycle vector table plus
// hand-written sequences for full/backpressure/wrap and reset mid-drain.
module tb_btb_update_queue;

  logic        clk;
  logic        rst_n;
  logic        resolve_valid;
  logic        resolve_ready;
  logic [31:0] resolve_pc;
  logic [31:0] resolve_target;
  logic        resolve_taken;
  logic        btb_w_en;
  logic [31:0] btb_commit_pc;
  logic [31:0] btb_actual_target_addr;
  logic        btb_wr_ready;
  logic [3:0]  occupancy;

  btb_update_queue #(.DEPTH(8)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .resolve_valid          (resolve_valid),
    .resolve_ready          (resolve_ready),
    .resolve_pc             (resolve_pc),
    .resolve_target         (resolve_target),
    .resolve_taken          (resolve_taken),
    .btb_w_en               (btb_w_en),
    .btb_commit_pc          (btb_commit_pc),
    .btb_actual_target_addr (btb_actual_target_addr),
    .btb_wr_ready           (btb_wr_ready),
    .occupancy              (occupancy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic        tk;
    logic [31:0] pc;
    logic [31:0] tg;
    logic        wr;
    logic        e_rdy;
    logic        e_wen;
    logic [31:0] e_pc;
    logic [31:0] e_tg;
    logic [3:0]  e_occ;
  } vec_t;

  vec_t        vecs[15];
  logic [63:0] exp_q[$];
  int          n_total;
  int          n_pass;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic check_outs(input string tag, input logic rdy, input logic wen,
                            input logic [31:0] pc, input logic [31:0] tg,
                            input logic [3:0] occ);
    chk({tag, ".ready"}, 32'(resolve_ready), 32'(rdy));
    chk({tag, ".w_en"},  32'(btb_w_en), 32'(wen));
    chk({tag, ".pc"},    btb_commit_pc, pc);
    chk({tag, ".tgt"},   btb_actual_target_addr, tg);
    chk({tag, ".occ"},   32'(occupancy), 32'(occ));
  endtask

  // driver: present inputs on the falling edge, sample 1ns after the rising edge
  task automatic drive(input logic v, input logic tk, input logic [31:0] pc,
                       input logic [31:0] tg, input logic wr);
    @(negedge clk);
    resolve_valid  = v;
    resolve_taken  = tk;
    resolve_pc     = pc;
    resolve_target = tg;
    btb_wr_ready   = wr;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic v, input logic tk, input logic [31:0] pc,
                              input logic [31:0] tg, input logic wr, input logic rdy,
                              input logic wen, input logic [31:0] epc,
                              input logic [31:0] etg, input logic [3:0] occ);
    vec_t r;
    r.v = v; r.tk = tk; r.pc = pc; r.tg = tg; r.wr = wr;
    r.e_rdy = rdy; r.e_wen = wen; r.e_pc = epc; r.e_tg = etg; r.e_occ = occ;
    return r;
  endfunction

  initial begin
    n_total = 0;
    n_pass  = 0;
    // expected outputs are the state after the edge that consumed the inputs
    vecs[0]  = mk(1, 1, 32'h1000, 32'h2000, 1, 1, 1, 32'h1000, 32'h2000, 1);
    vecs[1]  = mk(0, 0, 32'h0,    32'h0,    1, 1, 0, 32'h0,    32'h0,    0);
    vecs[2]  = mk(0, 0, 32'h0,    32'h0,    1, 1, 0, 32'h0,    32'h0,    0);
    vecs[3]  = mk(1, 0, 32'h1004, 32'hbeef, 1, 1, 0, 32'h0,    32'h0,    0);
    vecs[4]  = mk(1, 1, 32'h1000, 32'h2000, 0, 1, 1, 32'h1000, 32'h2000, 1);
    vecs[5]  = mk(1, 1, 32'h1010, 32'h3000, 0, 1, 1, 32'h1000, 32'h2000, 2);
    vecs[6]  = mk(1, 1, 32'h1010, 32'h4000, 0, 1, 1, 32'h1000, 32'h2000, 2);
    vecs[7]  = mk(0, 0, 32'h0,    32'h0,    1, 1, 1, 32'h1010, 32'h4000, 1);
    vecs[8]  = mk(0, 0, 32'h0,    32'h0,    1, 1, 0, 32'h0,    32'h0,    0);
    vecs[9]  = mk(1, 1, 32'h2000, 32'h5000, 0, 1, 1, 32'h2000, 32'h5000, 1);
    vecs[10] = mk(1, 1, 32'h2000, 32'h6000, 1, 1, 1, 32'h2000, 32'h6000, 1);
    vecs[11] = mk(0, 0, 32'h0,    32'h0,    1, 1, 0, 32'h0,    32'h0,    0);
    vecs[12] = mk(1, 1, 32'h3000, 32'h7000, 0, 1, 1, 32'h3000, 32'h7000, 1);
    vecs[13] = mk(1, 1, 32'h3000, 32'h7100, 0, 1, 1, 32'h3000, 32'h7100, 1);
    vecs[14] = mk(0, 0, 32'h0,    32'h0,    1, 1, 0, 32'h0,    32'h0,    0);

    rst_n = 1'b0;
    resolve_valid = 0; resolve_taken = 0; resolve_pc = 0; resolve_target = 0;
    btb_wr_ready = 1;
    #12;
    check_outs("reset", 1, 0, 32'h0, 32'h0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].v, vecs[i].tk, vecs[i].pc, vecs[i].tg, vecs[i].wr);
      check_outs($sformatf("vec%0d", i), vecs[i].e_rdy, vecs[i].e_wen,
                 vecs[i].e_pc, vecs[i].e_tg, vecs[i].e_occ);
    end

    // full queue, held ninth transfer, drain across pointer wrap
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      drive(1, 1, 32'h4000 + 32'(i * 4), 32'h8000 + 32'(i), 0);
      exp_q.push_back({32'h4000 + 32'(i * 4), 32'h8000 + 32'(i)});
      chk($sformatf("fill%0d.occ", i), 32'(occupancy), 32'(i + 1));
      chk($sformatf("fill%0d.ready", i), 32'(resolve_ready), (i == 7) ? 32'd0 : 32'd1);
    end
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 32'h4100, 32'h9000, 0);
      chk($sformatf("hold%0d.occ", i), 32'(occupancy), 32'd8);
      chk($sformatf("hold%0d.head_pc", i), btb_commit_pc, 32'h4000);
    end
    drive(1, 1, 32'h4100, 32'h9000, 1);
    chk("free1.occ", 32'(occupancy), 32'd7);
    chk("free1.ready", 32'(resolve_ready), 32'd1);
    drive(1, 1, 32'h4100, 32'h9000, 0);
    void'(exp_q.pop_front());
    exp_q.push_back({32'h4100, 32'h9000});
    chk("ninth.occ", 32'(occupancy), 32'd8);
    // scoreboard drain: head must match the expected queue each cycle
    @(negedge clk);
    resolve_valid = 0;
    btb_wr_ready  = 1;
    for (int i = 0; i < 12 && exp_q.size() != 0; i++) begin
      logic [63:0] e;
      e = exp_q.pop_front();
      chk($sformatf("drain%0d.w_en", i), 32'(btb_w_en), 32'd1);
      chk($sformatf("drain%0d.pc", i), btb_commit_pc, e[63:32]);
      chk($sformatf("drain%0d.tgt", i), btb_actual_target_addr, e[31:0]);
      @(negedge clk);
    end
    chk("drain.left", 32'(exp_q.size()), 32'd0);
    chk("drain.occ", 32'(occupancy), 32'd0);
    chk("drain.w_en", 32'(btb_w_en), 32'd0);

    // reset mid-drain
    for (int i = 0; i < 4; i++) drive(1, 1, 32'h5000 + 32'(i * 4), 32'ha000 + 32'(i), 0);
    chk("pre_rst.occ", 32'(occupancy), 32'd4);
    drive(0, 0, 32'h0, 32'h0, 1);
    chk("pre_rst.drain_occ", 32'(occupancy), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check_outs("mid_rst", 1, 0, 32'h0, 32'h0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 32'h0, 32'h0, 1);
      chk($sformatf("post_rst%0d.w_en", i), 32'(btb_w_en), 32'd0);
      chk($sformatf("post_rst%0d.occ", i), 32'(occupancy), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
